// File: rtl/attribute_interpolator.sv
// attribute_interpolator: blends per-vertex attributes by signed Q16.16 barycentric weights
// using a single time-shared multiply-accumulate, one product per cycle.
module attribute_interpolator #(
   parameter int NUM_ATTR = 3,
   parameter int ATTR_W   = 8,
   parameter int FRAC     = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       weights_valid,
   input  logic signed [31:0]         w0,
   input  logic signed [31:0]         w1,
   input  logic signed [31:0]         w2,
   input  logic [NUM_ATTR*ATTR_W-1:0] attr_v0,
   input  logic [NUM_ATTR*ATTR_W-1:0] attr_v1,
   input  logic [NUM_ATTR*ATTR_W-1:0] attr_v2,
   output logic                       weights_ready,
   output logic                       pix_valid,
   input  logic                       pix_ready,
   output logic [NUM_ATTR*ATTR_W-1:0] pix_attr,
   output logic                       busy,
   output logic                       drop_err
);
   localparam int LW = NUM_ATTR*ATTR_W;
   localparam int AW = 32+ATTR_W+3;
   localparam int IW = $clog2(NUM_ATTR+1);
   localparam logic [1:0] IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2;
   localparam logic signed [AW-1:0] HALF = AW'(1) << (FRAC-1);
   localparam logic signed [AW-1:0] MAXV = AW'((1 << ATTR_W) - 1);
   logic [1:0]             state;
   logic signed [31:0]     w_q [3];
   logic [LW-1:0]          a_q [3];
   logic signed [AW-1:0]   acc, prod, sum, t;
   logic [IW-1:0]          attr_idx;
   logic [1:0]             vtx_idx;
   logic [ATTR_W-1:0]      lane;
   logic                   accept;
   assign pix_valid     = state == OUT;
   assign busy          = state != IDLE;
   assign weights_ready = state == IDLE || (state == OUT && pix_ready);
   assign accept        = weights_valid && weights_ready;
   // Attribute is zero-extended to a positive signed operand before the signed multiply.
   always_comb begin
      prod = AW'(w_q[vtx_idx]) * AW'($signed({1'b0, a_q[vtx_idx][attr_idx*ATTR_W +: ATTR_W]}));
      sum  = acc + prod;
      t    = (sum + HALF) >>> FRAC;
      lane = t[AW-1] ? '0 : t > MAXV ? '1 : t[ATTR_W-1:0];
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         pix_attr <= '0;
         drop_err <= 1'b0;
         acc      <= '0;
         attr_idx <= '0;
         vtx_idx  <= '0;
         w_q      <= '{default: '0};
         a_q      <= '{default: '0};
      end else begin
         if (weights_valid && !weights_ready)
            drop_err <= 1'b1;
         if (accept) begin
            w_q      <= '{w0, w1, w2};
            a_q      <= '{attr_v0, attr_v1, attr_v2};
            acc      <= '0;
            attr_idx <= '0;
            vtx_idx  <= '0;
            state    <= MAC;
         end else if (state == MAC) begin
            if (vtx_idx == 2'd2) begin
               pix_attr[attr_idx*ATTR_W +: ATTR_W] <= lane;
               acc      <= '0;
               vtx_idx  <= '0;
               attr_idx <= attr_idx + IW'(1);
               if (attr_idx == IW'(NUM_ATTR-1))
                  state <= OUT;
            end else begin
               acc     <= sum;
               vtx_idx <= vtx_idx + 2'd1;
            end
         end else if (state == OUT && pix_ready) begin
            state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_attribute_interpolator.sv
// tb_attribute_interpolator: scoreboard bench for attribute_interpolator; expected pixels are
// queued on issue and compared when the DUT hands a pixel downstream.
module tb_attribute_interpolator;
   logic        clk = 1'b0, rst_n = 1'b0, weights_valid = 1'b0, pix_ready = 1'b1;
   logic [31:0] w0 = '0, w1 = '0, w2 = '0;
   logic [23:0] attr_v0 = '0, attr_v1 = '0, attr_v2 = '0;
   logic        weights_ready, pix_valid, busy, drop_err;
   logic [23:0] pix_attr;
   int          n_vec = 0, n_err = 0;
   logic [23:0] exp_q [$];

   always #5 clk = ~clk;

   attribute_interpolator #(.NUM_ATTR(3), .ATTR_W(8), .FRAC(16)) dut (
      .clk(clk), .rst_n(rst_n), .weights_valid(weights_valid),
      .w0(w0), .w1(w1), .w2(w2),
      .attr_v0(attr_v0), .attr_v1(attr_v1), .attr_v2(attr_v2),
      .weights_ready(weights_ready), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_attr(pix_attr), .busy(busy), .drop_err(drop_err)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] model(input logic signed [31:0] a, b, c,
                                         input logic [23:0] x, y, z);
      logic [23:0] r;
      longint s;
      r = '0;
      for (int k = 0; k < 3; k++) begin
         s = longint'(a) * longint'(x[k*8 +: 8]) + longint'(b) * longint'(y[k*8 +: 8])
           + longint'(c) * longint'(z[k*8 +: 8]);
         s = (s + 64'sd32768) >>> 16;
         r[k*8 +: 8] = s < 0 ? 8'h00 : s > 255 ? 8'hFF : s[7:0];
      end
      return r;
   endfunction

   // Retirement happens at the next rising edge when both valid and ready are high.
   always @(negedge clk) begin
      #1;
      if (rst_n && pix_valid && pix_ready) begin
         if (exp_q.size() == 0) chk("spurious_pix", 1, 0);
         else chk("pix", pix_attr, exp_q.pop_front());
      end
   end

   task automatic go(input logic [31:0] a, b, c, input logic [23:0] x, y, z,
                     input logic [23:0] e, input string tag);
      int lat;
      chk({tag, "_rdy"}, weights_ready, 1);
      w0 = a; w1 = b; w2 = c;
      attr_v0 = x; attr_v1 = y; attr_v2 = z;
      weights_valid = 1'b1;
      exp_q.push_back(e);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            weights_valid = 1'b0;
            w0 = $urandom; w1 = $urandom; w2 = $urandom;
            attr_v0 = 24'($urandom); attr_v1 = 24'($urandom); attr_v2 = 24'($urandom);
         end
      end while (!pix_valid && lat < 40);
      chk({tag, "_lat"}, lat, 10);
   endtask

   initial begin
      logic [31:0] rw [3];
      logic [23:0] ra [3];
      int n;
      repeat (3) @(negedge clk);
      chk("rst_valid", pix_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_drop", drop_err, 0);
      chk("rst_ready", weights_ready, 1);
      chk("rst_attr", pix_attr, 0);
      rst_n = 1'b1;
      @(negedge clk);
      go(32'h10000, 32'h0, 32'h0, 24'h804020, 24'h123456, 24'hABCDEF, 24'h804020, "ident");
      @(negedge clk);
      go(32'h5555, 32'h5555, 32'h5555, 24'h000030, 24'h000060, 24'h000090, 24'h000060, "third");
      go(32'h5555, 32'h5555, 32'h5555, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, "thirdff");
      go(32'h20000, 32'h0, 32'h0, 24'h0000FF, 24'h777777, 24'h777777, 24'h0000FF, "clamphi");
      go(32'hFFFF0000, 32'h0, 32'h0, 24'h404040, 24'h777777, 24'h777777, 24'h000000, "clamplo");
      go(32'h8000, 32'h0, 32'h0, 24'h010003, 24'h0, 24'h0, 24'h010002, "round");
      @(negedge clk);
      pix_ready = 1'b0;
      go(32'h8000, 32'h8000, 32'h0, 24'h102030, 24'h305070, 24'h0, 24'h203850, "bp");
      for (int i = 0; i < 6; i++) begin
         chk("bp_hold", pix_attr, 24'h203850);
         chk("bp_valid", pix_valid, 1);
         if (i == 2) begin
            weights_valid = 1'b1;
            w0 = 32'h10000; attr_v0 = 24'hEEEEEE;
         end
         if (i == 3) weights_valid = 1'b0;
         @(negedge clk);
      end
      chk("drop_set", drop_err, 1);
      pix_ready = 1'b1;
      @(negedge clk);
      chk("bp_retired", pix_valid, 0);
      chk("drop_sticky", drop_err, 1);
      go(32'h10000, 32'h10000, 32'h0, 24'h010203, 24'h020304, 24'h0, 24'h030507, "b2b_a");
      go(32'h0, 32'h0, 32'h10000, 24'h0, 24'h0, 24'hC0FFEE, 24'hC0FFEE, "b2b_b");
      @(negedge clk);
      w0 = 32'h10000; attr_v0 = 24'h111111;
      weights_valid = 1'b1;
      @(negedge clk);
      weights_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_busy", busy, 1);
      chk("mid_ready", weights_ready, 0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mrst_valid", pix_valid, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_ready", weights_ready, 1);
      chk("mrst_drop", drop_err, 0);
      rst_n = 1'b1;
      go(32'h0, 32'h10000, 32'h0, 24'h0, 24'h5A5AA5, 24'h0, 24'h5A5AA5, "after_rst");
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < 3; j++) begin
            rw[j] = 32'($urandom_range(0, 32'h20000)) - 32'h8000;
            ra[j] = 24'($urandom);
         end
         go(rw[0], rw[1], rw[2], ra[0], ra[1], ra[2],
            model(rw[0], rw[1], rw[2], ra[0], ra[1], ra[2]), "rnd");
      end
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("drain", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
